// File: rtl/stack_unit.sv
// Data stack for the stack-machine datapath: synchronous LIFO with registered
// read port, occupancy flags, sticky error flags and a fault-tracking FSM.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTRW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             empty,
  output logic             full,
  output logic [PTRW:0]    count,
  output logic             overflow,
  output logic             underflow,
  output logic             fault
);

  typedef enum logic {ST_OK, ST_ERR} state_t;

  localparam logic [PTRW:0] DEPTH_CNT = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0] ONE       = (PTRW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW:0]    sp, sp_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             dvalid_nxt;
  logic             mem_we;
  logic [PTRW-1:0]  wr_idx, top_idx;
  logic             ovf_set, unf_set;
  state_t           state_q, state_d;

  assign empty   = (sp == '0);
  assign full    = (sp == DEPTH_CNT);
  assign count   = sp;
  assign fault   = (state_q == ST_ERR);
  // Wraps to DEPTH-1 when sp == DEPTH, which is exactly the top slot.
  assign top_idx = sp[PTRW-1:0] - PTRW'(1);

  // Strobe decode; branch order is the priority between simultaneous strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    sp_nxt     = sp;
    dout_nxt   = dout;
    dvalid_nxt = 1'b0;
    mem_we     = 1'b0;
    wr_idx     = sp[PTRW-1:0];
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (push && pop) begin
      dvalid_nxt = 1'b1;
      if (!empty) begin
        dout_nxt = mem[top_idx];
        mem_we   = 1'b1;
        wr_idx   = top_idx;
      end else begin
        dout_nxt = din;
      end
    end else if (pop) begin
      if (!empty) begin
        dout_nxt   = mem[top_idx];
        sp_nxt     = sp - ONE;
        dvalid_nxt = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        mem_we = 1'b1;
        sp_nxt = sp + ONE;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (tos) begin
      if (!empty) begin
        dout_nxt   = mem[top_idx];
        dvalid_nxt = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= '0;
      dout      <= '0;
      dvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      dout      <= dout_nxt;
      dvalid    <= dvalid_nxt;
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
    end
  end

  // NOTE: the storage array has no reset; its contents are meaningless until
  // written, and sp alone decides what is readable.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_OK;
    else      state_q <= state_d;
  end

  // ERR is absorbing until reset.
  always_comb begin
    state_d = state_q;
    if (ovf_set || unf_set) state_d = ST_ERR;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Data stack for the stack-machine datapath. It is the responder to the controller's push, pop and tos strobes.
- It stores operands written from the datapath bus and returns the top-of-stack value to the ALU / memory-data path.
- It is a synchronous LIFO with a registered read port, occupancy flags and sticky error flags. A small state machine tracks whether the stack has faulted.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- PTRW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low; clears the stack when 0.
- push  input  1  controller strobe: write din onto the stack this cycle.
- pop  input  1  controller strobe: remove the top entry and present it on dout.
- tos  input  1  controller strobe: present the top entry on dout without removing it.
- din  input  WIDTH  data to push.
- dout  output  WIDTH  registered read data.
- dvalid  output  1  one-cycle pulse: dout was updated by the previous edge.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  PTRW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop or tos was attempted while empty.
- fault  output  1  high while the state machine is in ERR.

Behaviour:
- Reset (rst=0, asynchronous):
  - sp=0, dout=0, dvalid=0.
  - overflow=0, underflow=0, state=OK.
  - empty=1, full=0, count=0.
  - Memory contents are don't-care.
  - Reset takes effect immediately, even mid-operation; strobes during reset are ignored.
- sp is the next free slot, so count == sp and the top entry is mem[sp-1].
- empty and full are combinational from sp.
- Precedence per edge, first match wins:
  1. push & pop, not empty: replace top. dout<=mem[sp-1] (old top), mem[sp-1]<=din, sp unchanged, dvalid=1.
  2. push & pop, empty: pass-through. dout<=din, sp unchanged, no storage, no flag, dvalid=1.
  3. pop, not empty: dout<=mem[sp-1], sp<=sp-1, dvalid=1.
  4. pop (or pop & tos), empty: no state change except underflow<=1; dout held, dvalid=0.
  5. push, not full: mem[sp]<=din, sp<=sp+1, dvalid=0. A tos asserted in the same cycle is ignored.
  6. push, full: overflow<=1, memory and sp unchanged, dvalid=0.
  7. tos alone, not empty: dout<=mem[sp-1], sp unchanged, dvalid=1.
  8. tos alone, empty: underflow<=1, dout held, dvalid=0.
  9. No strobe: dvalid=0, all else held.
- pop & tos together is treated as pop.
- Latency:
  - dout is valid one cycle after the strobe edge, aligned with dvalid.
  - A pushed value is visible to tos/pop on the very next edge, with no bubble.
- State machine:
  - OK -> ERR on any edge that sets overflow or underflow.
  - ERR is absorbing until reset.
  - In ERR the stack keeps operating per the rules above; fault=1 so the controller can halt.
- Flags never self-clear; only rst clears them.
- sp never wraps: a push at full and a pop at empty leave sp unchanged.
- Arithmetic on sp is PTRW+1 bits. Memory index uses the low PTRW bits only.

Test Plan:
- Reset/ordering: release rst, push 0x11, 0x22, 0x33, then pop x3 -> dout 0x33, 0x22, 0x11 with dvalid pulsing each cycle; empty=1 afterwards; count sequence 1,2,3,2,1,0.
- tos non-destructive: push 0x5A, tos twice -> dout=0x5A both times, count stays 1, then pop -> 0x5A, empty=1.
- Full/overflow: push DEPTH values 0..7 -> full=1, count=8. Push 0xFF -> overflow=1, fault=1, count=8. Pop -> 0x07, not 0xFF.
- Underflow: from reset, pop then tos -> underflow=1, fault=1, dout=0, dvalid=0, count=0. Later push/pop still work and fault stays 1.
- Simultaneous strobes:
  - Stack holding [0x10, 0x20], push&pop with din=0x99 -> dout=0x20, count=2. Then pop -> 0x99.
  - On an empty stack, push&pop with din=0x44 -> dout=0x44, count=0, no flags.
- Async reset mid-operation: assert rst between clock edges while count=3 and flags set -> count=0, dout=0, flags=0, fault=0 immediately, without waiting for a clock edge. After release, the first pop underflows.
